// File: rtl/emm_arbiter.sv
// emm_arbiter: two-requester Wishbone pipelined arbiter for the external
// memory mux. Owns the mux select, gates master cyc/stb, routes stall/ack
// back to the owning requester and bounds in-flight master transfers.
module emm_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,          // synchronous, active-low
  input  logic             s1_cyc_i,
  input  logic             s1_stb_i,
  output logic             s1_stall_o,
  output logic             s1_ack_o,
  input  logic             s2_cyc_i,
  input  logic             s2_stb_i,
  output logic             s2_stall_o,
  output logic             s2_ack_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  input  logic             m_stall_i,
  input  logic             m_ack_i,
  output logic [1:0]       grant_o,
  output logic [CNT_W-1:0] outstanding_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last2_q, last2_d;   // 1: requester 2 owned the bus last
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic limit;
  logic ack_valid;
  logic accept;
  logic ack_routed;

  // Limit and ack qualification both use the registered count, so an ack
  // arriving at the limit cannot release the stall in the same cycle.
  assign limit     = (cnt_q == MaxCnt);
  assign ack_valid = m_ack_i & (cnt_q != '0);

  // Next-state, bus gating and ack routing.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    last2_d    = last2_q;
    cnt_d      = cnt_q;
    grant_o    = 2'b00;
    m_cyc_o    = 1'b0;
    m_stb_o    = 1'b0;
    s1_stall_o = 1'b1;
    s2_stall_o = 1'b1;
    s1_ack_o   = 1'b0;
    s2_ack_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Round-robin on contention: requester 1 wins unless it went last.
        if (s1_cyc_i && (!s2_cyc_i || last2_q)) begin
          state_d = OWN1;
          last2_d = 1'b0;
        end else if (s2_cyc_i) begin
          state_d = OWN2;
          last2_d = 1'b1;
        end
      end
      OWN1: begin
        grant_o    = 2'b01;
        m_cyc_o    = s1_cyc_i;
        m_stb_o    = s1_cyc_i & s1_stb_i & ~limit;
        s1_stall_o = m_stall_i | limit;
        s1_ack_o   = ack_valid;
        if (!s1_cyc_i) state_d = IDLE;
      end
      OWN2: begin
        grant_o    = 2'b10;
        m_cyc_o    = s2_cyc_i;
        m_stb_o    = s2_cyc_i & s2_stb_i & ~limit;
        s2_stall_o = m_stall_i | limit;
        s2_ack_o   = ack_valid;
        if (!s2_cyc_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept     = m_stb_o & ~m_stall_i;
    ack_routed = s1_ack_o | s2_ack_o;

    // Leaving ownership clears the count: on an abort the remaining acks
    // belong to a dead cycle and must not be routed to the next owner.
    if (state_q != IDLE && state_d == IDLE) begin
      cnt_d = '0;
    end else if (accept && !ack_routed) begin
      cnt_d = cnt_q + 1'b1;
    end else if (ack_routed && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign outstanding_o = cnt_q;

  // State, round-robin history and outstanding counter registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_i) begin
      state_q <= IDLE;
      last2_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last2_q <= last2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_emm_arbiter.sv
// tb_emm_arbiter: scoreboard bench. The stimulus process predicts every
// cycle's outputs from a behavioural model of the arbitration rules and
// queues them; a monitor on the falling edge pops and compares.
module tb_emm_arbiter;

  localparam int MAX = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       s1_cyc_i = 1'b0, s1_stb_i = 1'b0;
  logic       s2_cyc_i = 1'b0, s2_stb_i = 1'b0;
  logic       m_stall_i = 1'b0, m_ack_i = 1'b0;
  logic       s1_stall_o, s1_ack_o, s2_stall_o, s2_ack_o;
  logic       m_cyc_o, m_stb_o;
  logic [1:0] grant_o;
  logic [3:0] outstanding_o;

  emm_arbiter #(.MAX_OUTSTANDING(MAX), .CNT_W(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s1_cyc_i     (s1_cyc_i),
    .s1_stb_i     (s1_stb_i),
    .s1_stall_o   (s1_stall_o),
    .s1_ack_o     (s1_ack_o),
    .s2_cyc_i     (s2_cyc_i),
    .s2_stb_i     (s2_stb_i),
    .s2_stall_o   (s2_stall_o),
    .s2_ack_o     (s2_ack_o),
    .m_cyc_o      (m_cyc_o),
    .m_stb_o      (m_stb_o),
    .m_stall_i    (m_stall_i),
    .m_ack_i      (m_ack_i),
    .grant_o      (grant_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] grant;
    logic       m_cyc, m_stb, s1_stall, s2_stall, s1_ack, s2_ack;
    logic [3:0] outst;
    int         cyc_no;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Reference model: owner 0 = nobody, 1/2 = requester; count of in-flight
  // master transfers; last owner for round-robin.
  int m_owner = 0;
  int m_cnt   = 0;
  int m_last  = 2;

  task automatic check(input string name, input int cyc, input logic [7:0] act,
                       input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict outputs, advance the model.
  task automatic cycle(input logic r, input logic c1, input logic t1,
                       input logic c2, input logic t2, input logic st,
                       input logic ak);
    exp_t e;
    logic ocyc, ostb, lim, ackv, acc;
    @(posedge clk_i);
    #1;
    rst_i = r; s1_cyc_i = c1; s1_stb_i = t1; s2_cyc_i = c2; s2_stb_i = t2;
    m_stall_i = st; m_ack_i = ak;
    cyc_no++;

    ocyc = (m_owner == 1) ? c1 : (m_owner == 2) ? c2 : 1'b0;
    ostb = (m_owner == 1) ? t1 : (m_owner == 2) ? t2 : 1'b0;
    lim  = (m_cnt == MAX);
    ackv = ak && (m_cnt > 0) && (m_owner != 0);
    e.grant    = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e.m_cyc    = ocyc;
    e.m_stb    = ocyc && ostb && !lim;
    e.s1_stall = (m_owner == 1) ? (st || lim) : 1'b1;
    e.s2_stall = (m_owner == 2) ? (st || lim) : 1'b1;
    e.s1_ack   = ackv && (m_owner == 1);
    e.s2_ack   = ackv && (m_owner == 2);
    e.outst    = 4'(m_cnt);
    e.cyc_no   = cyc_no;
    exp_q.push_back(e);

    acc = e.m_stb && !st;
    if (!r) begin
      m_owner = 0; m_cnt = 0; m_last = 2;
    end else if (m_owner == 0) begin
      if (c1 && c2) m_owner = (m_last == 1) ? 2 : 1;
      else if (c1)  m_owner = 1;
      else if (c2)  m_owner = 2;
      if (m_owner != 0) m_last = m_owner;
    end else if (!ocyc) begin
      m_owner = 0; m_cnt = 0;
    end else begin
      m_cnt = m_cnt + (acc ? 1 : 0) - (ackv ? 1 : 0);
    end
  endtask

  // Monitor: compare the DUT against the queued prediction mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant",    e.cyc_no, 8'(grant_o),       8'(e.grant));
        check("m_cyc",    e.cyc_no, 8'(m_cyc_o),       8'(e.m_cyc));
        check("m_stb",    e.cyc_no, 8'(m_stb_o),       8'(e.m_stb));
        check("s1_stall", e.cyc_no, 8'(s1_stall_o),    8'(e.s1_stall));
        check("s2_stall", e.cyc_no, 8'(s2_stall_o),    8'(e.s2_stall));
        check("s1_ack",   e.cyc_no, 8'(s1_ack_o),      8'(e.s1_ack));
        check("s2_ack",   e.cyc_no, 8'(s2_ack_o),      8'(e.s2_ack));
        check("outstand", e.cyc_no, 8'(outstanding_o), 8'(e.outst));
      end
    end
  end

  initial begin : stimulus
    logic c1, c2;
    int   guard;
    // Let the reset take hold before predictions begin.
    @(posedge clk_i);
    @(posedge clk_i);

    // Reset held with both requesters asking, then released: 1 wins.
    cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0, 0, 0);

    // Requester 1 streams into the limit, one ack reopens it, then drains.
    for (int i = 0; i < 7; i++) cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0, 0);
    guard = 0;
    while (m_cnt > 0 && guard < 20) begin
      cycle(1, 1, 0, 0, 0, 0, 1);
      guard++;
    end
    // Simultaneous accept and ack at count 1, then drain and release.
    cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    // Spurious ack in IDLE.
    cycle(1, 0, 0, 0, 0, 0, 1);

    // Round-robin: both hold cyc, each owner does one transfer then drops.
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (m_owner == 0 && guard < 4) begin
        cycle(1, 1, 0, 1, 0, 0, 0);
        guard++;
      end
      cycle(1, 1, 1, 1, 1, 0, 0);
      cycle(1, 1, 0, 1, 0, 0, 1);
      if (m_owner == 1) cycle(1, 0, 0, 1, 0, 0, 0);
      else              cycle(1, 1, 0, 0, 0, 0, 0);
    end
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Abort: requester 2 gets two beats out, drops cyc, stray ack follows.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with sticky cyc and occasional mid-transfer reset.
    c1 = 1'b0;
    c2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) c1 = ~c1;
      if ($urandom_range(7) == 0) c2 = ~c2;
      cycle(($urandom_range(199) != 0), c1, 1'($urandom_range(1)),
            c2, 1'($urandom_range(1)), ($urandom_range(3) == 0),
            ($urandom_range(9) < 3));
    end

    // Allow the monitor to consume the last prediction.
    @(negedge clk_i);
    @(negedge clk_i);
    check("scoreboard_drained", cyc_no, 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
